// File: rtl/constellation_demap.sv
// constellation_demap: hard-decision QPSK/16QAM slicer, 2-stage valid/ready pipeline
// with an accepted-symbol counter; output bit layout matches the transmit mapper.
module constellation_demap #(
  parameter int SCALE = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_I,
  input  logic [31:0]      in_Q,
  input  logic             in_mod_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_symbol,
  output logic             out_mod_type,
  output logic [CNT_W-1:0] sym_count,
  input  logic             cnt_clear
);
  localparam logic [32:0] T = 33'(2 * SCALE);
  logic             advance;
  logic             v1_q, si_q, sq_q, m1_q;
  logic [32:0]      mi_q, mq_q, mi_d, mq_d;
  logic             ov_q, om_q;
  logic [3:0]       sym_q, sym_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Magnitudes are 33 bits wide so that |-2^31| = 2^31 is representable.
  always_comb begin
    advance = !ov_q | out_ready;
    mi_d    = {1'b0, in_I[31] ? 32'(-in_I) : in_I};
    mq_d    = {1'b0, in_Q[31] ? 32'(-in_Q) : in_Q};
    sym_d   = m1_q ? {si_q, sq_q, mi_q > T, mq_q > T} : {2'b00, sq_q, si_q};
    cnt_d   = cnt_clear ? '0 : (ov_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q  <= 1'b0;
      si_q  <= 1'b0;
      sq_q  <= 1'b0;
      m1_q  <= 1'b0;
      mi_q  <= '0;
      mq_q  <= '0;
      ov_q  <= 1'b0;
      om_q  <= 1'b0;
      sym_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        v1_q  <= in_valid;
        ov_q  <= v1_q;
        sym_q <= sym_d;
        om_q  <= m1_q;
      end
      if (advance && in_valid) begin
        si_q <= in_I[31];
        sq_q <= in_Q[31];
        mi_q <= mi_d;
        mq_q <= mq_d;
        m1_q <= in_mod_type;
      end
    end
  assign in_ready     = advance;
  assign out_valid    = ov_q;
  assign out_symbol   = sym_q;
  assign out_mod_type = om_q;
  assign sym_count    = cnt_q;
endmodule

// File: tb/tb_constellation_demap.sv
// tb_constellation_demap: randomized and directed stimulus checked against a
// behavioural demapper model with a queue-based scoreboard.
module tb_constellation_demap;
  localparam int SCALE = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_mod_type;
  logic [31:0] in_I, in_Q;
  logic        out_valid, out_ready, out_mod_type, cnt_clear;
  logic [3:0]  out_symbol;
  logic [31:0] sym_count;
  typedef struct {logic [3:0] sym; logic mod; int e;} exp_t;
  exp_t        q[$];
  int          n_tests = 0, n_fail = 0, edge_n = 0, rdy_mode = 0;
  logic [31:0] exp_cnt = 0;
  bit          lat_chk = 0, stall_prev = 0, acc = 0;
  logic [3:0]  prev_sym;
  logic        prev_mod;
  logic [5:0]  pat = 6'b101001;
  always #5 clk = ~clk;
  constellation_demap #(.SCALE(SCALE), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_I(in_I), .in_Q(in_Q), .in_mod_type(in_mod_type), .out_valid(out_valid),
    .out_ready(out_ready), .out_symbol(out_symbol), .out_mod_type(out_mod_type),
    .sym_count(sym_count), .cnt_clear(cnt_clear)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Symbol decided from signed integer values and plain magnitude arithmetic.
  function automatic logic [3:0] ref_sym(int i, int qv, logic m);
    longint t  = 2 * SCALE;
    longint ai = i < 0 ? -longint'(i) : longint'(i);
    longint aq = qv < 0 ? -longint'(qv) : longint'(qv);
    return m ? {i < 0, qv < 0, ai > t, aq > t} : {2'b00, qv < 0, i < 0};
  endfunction
  task automatic cyc();
    exp_t e;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[edge_n % 6] : 1'($urandom_range(0, 1));
    #1;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sym", out_symbol, prev_sym);
      chk("hold_mod", out_mod_type, prev_mod);
    end
    stall_prev = out_valid && !out_ready;
    prev_sym = out_symbol;
    prev_mod = out_mod_type;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("symbol", out_symbol, e.sym);
        chk("out_mod", out_mod_type, e.mod);
        if (lat_chk) chk("latency", edge_n + 1 - e.e, 2);
      end
      exp_cnt++;
    end
    if (cnt_clear) exp_cnt = 0;
    acc = in_valid && in_ready;
    if (acc) q.push_back('{ref_sym(int'(in_I), int'(in_Q), in_mod_type), in_mod_type, edge_n + 1});
    @(posedge clk);
    edge_n++;
    #1;
    chk("sym_count", sym_count, exp_cnt);
  endtask
  task automatic send(int i, int qv, logic m);
    int tries = 0;
    in_valid = 1'b1;
    in_I = i;
    in_Q = qv;
    in_mod_type = m;
    do begin
      cyc();
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int tries = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && tries < 50) begin
      cyc();
      tries++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    in_valid = 0; in_I = 0; in_Q = 0; in_mod_type = 0; out_ready = 1; cnt_clear = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sym", out_symbol, 0);
    chk("rst_mod", out_mod_type, 0);
    chk("rst_count", sym_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", in_ready, 1);
    // Round trip over every 16QAM mapper point, symbols 0000..1111 in order.
    lat_chk = 1;
    for (int k = 0; k < 16; k++)
      send((k & 8 ? -1 : 1) * (k & 2 ? 3 : 1) * SCALE, (k & 4 ? -1 : 1) * (k & 1 ? 3 : 1) * SCALE, 1'b1);
    drain();
    chk("rt_count", sym_count, 16);
    send(3 * SCALE, 3 * SCALE, 0);
    send(-3 * SCALE, 3 * SCALE, 0);
    send(3 * SCALE, -3 * SCALE, 0);
    send(-3 * SCALE, -3 * SCALE, 0);
    drain();
    // Decision boundaries around T = 2*SCALE and the most negative input.
    send(2 * SCALE, 0, 1);
    send(2 * SCALE + 1, 0, 1);
    send(0, 0, 1);
    send(-2 * SCALE, 0, 1);
    send(int'(32'h8000_0000), 0, 1);
    send(0, 2 * SCALE, 1);
    send(0, 2 * SCALE + 1, 1);
    send(0, int'(32'h8000_0000), 1);
    drain();
    for (int k = 0; k < 8; k++) send(-3 * SCALE, SCALE, 1'(k));
    drain();
    // Backpressure with the 1,0,0,1,0,1 ready pattern.
    lat_chk = 0;
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) send(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20, 1'($urandom_range(0, 1)));
    drain();
    chk("bp_count", sym_count, 6);
    rdy_mode = 0;
    send(SCALE, SCALE, 1);
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;
    chk("clr_on_xfer", sym_count, 0);
    drain();
    rdy_mode = 2;
    for (int k = 0; k < 400; k++) begin
      int v[2];
      for (int j = 0; j < 2; j++)
        case ($urandom_range(0, 5))
          0: v[j] = int'($urandom);
          1: v[j] = 2 * SCALE;
          2: v[j] = 2 * SCALE + 1;
          3: v[j] = -2 * SCALE;
          4: v[j] = int'(32'h8000_0000);
          default: v[j] = int'($urandom_range(0, 32 * SCALE)) - 16 * SCALE;
        endcase
      in_valid = 1'($urandom_range(0, 1));
      in_I = v[0];
      in_Q = v[1];
      in_mod_type = 1'($urandom_range(0, 1));
      cnt_clear = $urandom_range(0, 19) == 0;
      cyc();
    end
    cnt_clear = 0;
    rdy_mode = 0;
    drain();
    // Asynchronous reset with two samples in flight.
    in_valid = 1; in_I = -SCALE; in_Q = SCALE; in_mod_type = 1;
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sym", out_symbol, 0);
    chk("midrst_count", sym_count, 0);
    q.delete();
    exp_cnt = 0;
    stall_prev = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      cyc();
      chk("post_rst_valid", out_valid, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
